// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg: shared state encodings, COND codes and decode constants
package micro_sequencer_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_WAIT_ACK = 2'b01} state_e;
  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;
  localparam logic DECODE_MSB = 1'b1;
  localparam logic [10:0] DEFAULT_TRAP_ADDR = 11'h7F0;
endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: microword/memory-status inputs and sequencer outputs
interface micro_sequencer_if #(parameter int CS_ADDR_W = 11);
  logic [2:0]           MICRO_SEQUENCER_COND_InBus;
  logic [CS_ADDR_W-1:0] MICRO_SEQUENCER_JUMPADDR_InBus;
  logic [31:0]          MICRO_SEQUENCER_IR_InBus;
  logic [3:0]           MICRO_SEQUENCER_FLAGS_InBus;
  logic                 MICRO_SEQUENCER_MEMREQ;
  logic                 MICRO_SEQUENCER_ACK;
  logic [CS_ADDR_W-1:0] MICRO_SEQUENCER_CSAddress_OutBus;
  logic                 MICRO_SEQUENCER_STALL;
  logic                 MICRO_SEQUENCER_FAULT;
  logic [1:0]           MICRO_SEQUENCER_STATE_OutBus;
  modport master (
    output MICRO_SEQUENCER_COND_InBus, MICRO_SEQUENCER_JUMPADDR_InBus, MICRO_SEQUENCER_IR_InBus,
           MICRO_SEQUENCER_FLAGS_InBus, MICRO_SEQUENCER_MEMREQ, MICRO_SEQUENCER_ACK,
    input  MICRO_SEQUENCER_CSAddress_OutBus, MICRO_SEQUENCER_STALL, MICRO_SEQUENCER_FAULT,
           MICRO_SEQUENCER_STATE_OutBus
  );
  modport slave (
    input  MICRO_SEQUENCER_COND_InBus, MICRO_SEQUENCER_JUMPADDR_InBus, MICRO_SEQUENCER_IR_InBus,
           MICRO_SEQUENCER_FLAGS_InBus, MICRO_SEQUENCER_MEMREQ, MICRO_SEQUENCER_ACK,
    output MICRO_SEQUENCER_CSAddress_OutBus, MICRO_SEQUENCER_STALL, MICRO_SEQUENCER_FAULT,
           MICRO_SEQUENCER_STATE_OutBus
  );
endinterface

// File: rtl/micro_sequencer_next_addr.sv
// micro_sequencer_next_addr: combinational next-microaddress multiplexer
module micro_sequencer_next_addr
  import micro_sequencer_pkg::*;
#(
  parameter int CS_ADDR_W = 11
) (
  input  logic [2:0]           cond_i,
  input  logic [CS_ADDR_W-1:0] cs_addr_i,
  input  logic [CS_ADDR_W-1:0] jump_addr_i,
  input  logic [31:0]          ir_i,
  input  logic [3:0]           flags_i,
  output logic [CS_ADDR_W-1:0] next_o
);
  logic                 take;
  logic [CS_ADDR_W-1:0] seq_addr;
  logic [CS_ADDR_W-1:0] dec_addr;
  // flags are packed {N,Z,V,C}
  assign take = (cond_i == COND_N    & flags_i[3]) |
                (cond_i == COND_Z    & flags_i[2]) |
                (cond_i == COND_V    & flags_i[1]) |
                (cond_i == COND_C    & flags_i[0]) |
                (cond_i == COND_IR13 & ir_i[13])   |
                (cond_i == COND_JUMP);
  assign seq_addr = cs_addr_i + CS_ADDR_W'(1);
  assign dec_addr = CS_ADDR_W'({DECODE_MSB, ir_i[31:30], ir_i[24:19], 2'b00});
  assign next_o   = (cond_i == COND_DECODE) ? dec_addr : take ? jump_addr_i : seq_addr;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store address register with memory-ACK stall and timeout trap
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int                   CS_ADDR_W = 11,
  parameter int                   TIMEOUT   = 16,
  parameter logic [CS_ADDR_W-1:0] TRAP_ADDR = CS_ADDR_W'(DEFAULT_TRAP_ADDR)
) (
  input  logic              MICRO_SEQUENCER_CLOCK_50,
  input  logic              MICRO_SEQUENCER_RESET_InHigh,
  micro_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  state_e               state_q, state_d;
  logic [CS_ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fault_q, fault_d;
  logic                 memreq, ack;
  assign memreq = bus.MICRO_SEQUENCER_MEMREQ;
  assign ack    = bus.MICRO_SEQUENCER_ACK;
  micro_sequencer_next_addr #(.CS_ADDR_W(CS_ADDR_W)) u_next_addr (
    .cond_i      (bus.MICRO_SEQUENCER_COND_InBus),
    .cs_addr_i   (addr_q),
    .jump_addr_i (bus.MICRO_SEQUENCER_JUMPADDR_InBus),
    .ir_i        (bus.MICRO_SEQUENCER_IR_InBus),
    .flags_i     (bus.MICRO_SEQUENCER_FLAGS_InBus),
    .next_o      (next_addr)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      ST_RUN: begin
        if (memreq & ~ack) begin
          state_d = ST_WAIT_ACK;
          cnt_d   = CNT_W'(1);
        end else addr_d = next_addr;
      end
      ST_WAIT_ACK: begin
        // ACK takes priority over a coincident timeout
        if (ack) begin
          addr_d  = next_addr;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          addr_d  = TRAP_ADDR;
          fault_d = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = ST_RUN;
        addr_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
    if (MICRO_SEQUENCER_RESET_InHigh) begin
      state_q <= ST_RUN;
      addr_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign bus.MICRO_SEQUENCER_STALL = ((state_q == ST_RUN) & memreq & ~ack) |
                                     ((state_q == ST_WAIT_ACK) & ~ack);
  assign bus.MICRO_SEQUENCER_CSAddress_OutBus = addr_q;
  assign bus.MICRO_SEQUENCER_FAULT            = fault_q;
  assign bus.MICRO_SEQUENCER_STATE_OutBus     = state_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vectors with hand-computed expectations
module tb_micro_sequencer;
  import micro_sequencer_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cond;
  logic [10:0] jump;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        memreq, ack;
  logic [10:0] addr;
  logic        stall, fault;
  logic [1:0]  state;
  int          checks = 0;
  int          failures = 0;
  micro_sequencer_if #(.CS_ADDR_W(11)) bus ();
  assign bus.MICRO_SEQUENCER_COND_InBus     = cond;
  assign bus.MICRO_SEQUENCER_JUMPADDR_InBus = jump;
  assign bus.MICRO_SEQUENCER_IR_InBus       = ir;
  assign bus.MICRO_SEQUENCER_FLAGS_InBus    = flags;
  assign bus.MICRO_SEQUENCER_MEMREQ         = memreq;
  assign bus.MICRO_SEQUENCER_ACK            = ack;
  assign addr  = bus.MICRO_SEQUENCER_CSAddress_OutBus;
  assign stall = bus.MICRO_SEQUENCER_STALL;
  assign fault = bus.MICRO_SEQUENCER_FAULT;
  assign state = bus.MICRO_SEQUENCER_STATE_OutBus;
  micro_sequencer #(.CS_ADDR_W(11), .TIMEOUT(16), .TRAP_ADDR(11'h7F0)) dut (
    .MICRO_SEQUENCER_CLOCK_50     (clk),
    .MICRO_SEQUENCER_RESET_InHigh (rst),
    .bus                          (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; cond = COND_NEXT; jump = '0; ir = '0; flags = '0; memreq = 1'b0; ack = 1'b0;
    tick(); tick();
    chk("rst_addr", addr, 0);
    chk("rst_state", state, 0);
    chk("rst_fault", fault, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_addr", addr, i);
      chk("seq_stall", stall, 0);
    end
    cond = COND_JUMP; jump = 11'h7FF; tick();
    chk("jump_7ff", addr, 11'h7FF);
    cond = COND_NEXT; tick();
    chk("wrap", addr, 11'h000);
    cond = COND_Z; jump = 11'h123; flags = 4'b0100; tick();
    chk("z_taken", addr, 11'h123);
    cond = COND_JUMP; jump = 11'h050; flags = 4'b0000; tick();
    cond = COND_Z; jump = 11'h123; tick();
    chk("z_not_taken", addr, 11'h051);
    cond = COND_IR13; jump = 11'h2AA; ir = 32'h0000_2000; tick();
    chk("ir13_taken", addr, 11'h2AA);
    cond = COND_N; jump = 11'h111; flags = 4'b1000; ir = '0; tick();
    chk("n_taken", addr, 11'h111);
    cond = COND_C; jump = 11'h3C3; flags = 4'b0010; tick();
    chk("c_not_taken_v_set", addr, 11'h112);
    cond = COND_DECODE; ir = 32'hC1F8_0000; flags = '0; tick();
    chk("decode_7fc", addr, 11'h7FC);
    ir = 32'h4008_0000; tick();
    chk("decode_504", addr, 11'h504);
    ir = '0;
    cond = COND_JUMP; jump = 11'h010; tick();
    chk("at_010", addr, 11'h010);
    cond = COND_NEXT; memreq = 1'b1; ack = 1'b0; #1;
    chk("mem_stall_run", stall, 1);
    tick();
    chk("mem_state_wait", state, 1);
    chk("mem_stall_w1", stall, 1);
    chk("mem_hold1", addr, 11'h010);
    tick();
    chk("mem_stall_w2", stall, 1);
    chk("mem_hold2", addr, 11'h010);
    tick();
    ack = 1'b1; #1;
    chk("mem_stall_ack", stall, 0);
    tick();
    chk("mem_after_ack", addr, 11'h011);
    chk("mem_state_run", state, 0);
    ack = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    chk("to_hold", addr, 11'h011);
    chk("to_state_wait", state, 1);
    chk("to_fault_pre", fault, 0);
    chk("to_stall", stall, 1);
    tick();
    chk("to_trap_addr", addr, 11'h7F0);
    chk("to_fault", fault, 1);
    chk("to_state_run", state, 0);
    memreq = 1'b0; tick();
    chk("trap_seq", addr, 11'h7F1);
    chk("fault_sticky", fault, 1);
    cond = COND_JUMP; jump = 11'h020; tick();
    cond = COND_NEXT; memreq = 1'b1;
    for (int i = 1; i <= 15; i++) tick();
    ack = 1'b1; tick();
    chk("ack16_no_trap", addr, 11'h021);
    chk("ack16_state", state, 0);
    chk("ack16_fault_still", fault, 1);
    ack = 1'b0; tick(); tick(); tick();
    chk("mid_stall_state", state, 1);
    rst = 1'b1; ack = 1'b1; tick();
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_fault", fault, 0);
    rst = 1'b0; memreq = 1'b0; ack = 1'b0; tick();
    chk("post_rst_seq", addr, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
